// File: rtl/seq_addsub_n.sv
// seq_addsub_n: multi-cycle WIDTH-bit adder/subtractor that sums one CHUNK-bit
// slice per clock, with valid/ready handshakes and carry/overflow/zero flags.
`default_nettype none

module seq_addsub_n #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             Op,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Suma,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;
   logic [WIDTH-1:0] partial_q, partial_d;
   logic [WIDTH-1:0] suma_q, suma_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;

   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] full_sum;
   int               base;

   always_comb begin
      base      = int'(idx_q) * CHUNK;
      slice_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, bx_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
      // Only the current slice is combinational; earlier slices come from partial_q.
      full_sum               = partial_q;
      full_sum[base +: CHUNK] = slice_sum[CHUNK-1:0];

      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      bx_d        = bx_q;
      partial_d   = partial_q;
      carry_d     = carry_q;
      suma_d      = suma_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d       = A;
               bx_d      = Op ? ~B : B;
               carry_d   = Op ^ Cin;
               partial_d = '0;
               idx_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            partial_d = full_sum;
            carry_d   = slice_sum[CHUNK];
            if (idx_q == LAST_IDX) begin
               suma_d      = full_sum;
               cout_d      = slice_sum[CHUNK];
               ovf_d       = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                             (full_sum[WIDTH-1] != a_q[WIDTH-1]);
               zero_d      = (full_sum == '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         bx_q        <= '0;
         partial_q   <= '0;
         carry_q     <= 1'b0;
         suma_q      <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         bx_q        <= bx_d;
         partial_q   <= partial_d;
         carry_q     <= carry_d;
         suma_q      <= suma_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign Suma      = suma_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;
   assign Zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_n.sv
// tb_seq_addsub_n: directed and reference-model checks of seq_addsub_n in the
// 16/4, 8/8 and 32/8 configurations.
`default_nettype none

module tb_seq_addsub_n;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0] a_in [3];
   logic [31:0] b_in [3];
   logic        iv [3];
   logic        ordy [3];
   logic        opv [3];
   logic        cinv [3];

   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic        co0, co1, co2;
   logic        vf0, vf1, vf2;
   logic        zf0, zf1, zf2;
   logic [15:0] s0;
   logic [7:0]  s1;
   logic [31:0] s2;

   int n_checks = 0;
   int n_fail   = 0;

   seq_addsub_n #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy0),
      .Op(opv[0]), .Cin(cinv[0]), .A(a_in[0][15:0]), .B(b_in[0][15:0]),
      .out_valid(ov0), .out_ready(ordy[0]), .Suma(s0), .Cout(co0), .Ovf(vf0), .Zero(zf0));

   seq_addsub_n #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy1),
      .Op(opv[1]), .Cin(cinv[1]), .A(a_in[1][7:0]), .B(b_in[1][7:0]),
      .out_valid(ov1), .out_ready(ordy[1]), .Suma(s1), .Cout(co1), .Ovf(vf1), .Zero(zf1));

   seq_addsub_n #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(rdy2),
      .Op(opv[2]), .Cin(cinv[2]), .A(a_in[2]), .B(b_in[2]),
      .out_valid(ov2), .out_ready(ordy[2]), .Suma(s2), .Cout(co2), .Ovf(vf2), .Zero(zf2));

   function automatic logic obs_rdy(int w);
      return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy2;
   endfunction

   function automatic logic obs_ov(int w);
      return (w == 0) ? ov0 : (w == 1) ? ov1 : ov2;
   endfunction

   function automatic logic [31:0] obs_sum(int w);
      return (w == 0) ? {16'h0, s0} : (w == 1) ? {24'h0, s1} : s2;
   endfunction

   function automatic logic [2:0] obs_flags(int w);
      return (w == 0) ? {co0, vf0, zf0} : (w == 1) ? {co1, vf1, zf1} : {co2, vf2, zf2};
   endfunction

   // Full-width arithmetic reference: {Cout, Ovf, Zero, sum}.
   function automatic logic [34:0] model(int wd, logic [31:0] a, logic [31:0] b,
                                         logic op, logic cin);
      logic [31:0] mask, am, bx, s;
      logic [32:0] full;
      logic        co, vf, zf;
      mask = (wd == 32) ? 32'hFFFF_FFFF : ((32'h1 << wd) - 32'h1);
      am   = a & mask;
      bx   = (op ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bx} + {32'h0, op ^ cin};
      s    = full[31:0] & mask;
      co   = full[wd];
      vf   = (am[wd-1] == bx[wd-1]) && (s[wd-1] != am[wd-1]);
      zf   = (s == 32'h0);
      return {co, vf, zf, s};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one operation and leave the DUT holding its result in DONE.
   task automatic run_op(input int w, input int lat, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic cin, input logic [31:0] es,
                         input logic [2:0] ef, input string tag);
      int cnt;
      cnt = 0;
      while (!obs_rdy(w) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " in_ready"}, 32'(obs_rdy(w)), 32'd1);
      a_in[w] = a; b_in[w] = b; opv[w] = op; cinv[w] = cin; iv[w] = 1'b1;
      @(negedge clk);
      iv[w] = 1'b0; a_in[w] = ~a; b_in[w] = ~b; opv[w] = ~op; cinv[w] = ~cin;
      check({tag, " busy"}, 32'(obs_rdy(w)), 32'd0);
      cnt = 0;
      while (!obs_ov(w) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " latency"}, 32'(cnt), 32'(lat));
      check({tag, " sum"}, obs_sum(w), es);
      check({tag, " flags"}, 32'(obs_flags(w)), 32'(ef));
   endtask

   task automatic drain(input int w, input string tag);
      ordy[w] = 1'b1;
      @(negedge clk);
      ordy[w] = 1'b0;
      check({tag, " drain out_valid"}, 32'(obs_ov(w)), 32'd0);
      check({tag, " drain in_ready"}, 32'(obs_rdy(w)), 32'd1);
   endtask

   task automatic rand_sweep(input int w, input int wd, input int lat);
      logic [31:0] a, b;
      logic        op, cin;
      logic [34:0] m;
      for (int i = 0; i < 500; i++) begin
         a   = $urandom();
         b   = $urandom();
         op  = 1'($urandom_range(0, 1));
         cin = 1'($urandom_range(0, 1));
         if (wd < 32) begin
            a = a & ((32'h1 << wd) - 32'h1);
            b = b & ((32'h1 << wd) - 32'h1);
         end
         m = model(wd, a, b, op, cin);
         run_op(w, lat, a, b, op, cin, m[31:0], m[34:32], $sformatf("rand w%0d #%0d", wd, i));
         drain(w, "rand");
      end
   endtask

   initial begin
      logic seen_valid;
      for (int i = 0; i < 3; i++) begin
         a_in[i] = '0; b_in[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b0;
         opv[i] = 1'b0; cinv[i] = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(rdy0), 32'd1);
      check("reset out_valid", 32'(ov0), 32'd0);
      check("reset sum", {16'h0, s0}, 32'h0);
      check("reset flags", 32'({co0, vf0, zf0}), 32'd0);
      check("reset w8 ready", 32'(rdy1), 32'd1);
      check("reset w32 ready", 32'(rdy2), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors, 16-bit / 4-bit chunks; flags are {Cout, Ovf, Zero}.
      run_op(0, 4, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 3'b000, "add basic");
      drain(0, "add basic");
      run_op(0, 4, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 3'b101, "carry ripple");
      drain(0, "carry ripple");
      run_op(0, 4, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 3'b010, "add ovf");
      drain(0, "add ovf");
      run_op(0, 4, 32'h0005, 32'h0007, 1'b1, 1'b0, 32'hFFFE, 3'b000, "sub borrow");
      drain(0, "sub borrow");
      run_op(0, 4, 32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 3'b110, "sub ovf");
      drain(0, "sub ovf");
      run_op(0, 4, 32'h0010, 32'h0001, 1'b1, 1'b1, 32'h000E, 3'b100, "sub borrow-in");
      drain(0, "sub borrow-in");
      run_op(0, 4, 32'h00FF, 32'h0000, 1'b0, 1'b1, 32'h0100, 3'b000, "add carry-in");

      // Backpressure: result held while a new request is offered and ignored.
      for (int k = 0; k < 3; k++) begin
         a_in[0] = 32'h1111; b_in[0] = 32'h1111; iv[0] = 1'b1;
         @(negedge clk);
         check("bp out_valid", 32'(ov0), 32'd1);
         check("bp in_ready", 32'(rdy0), 32'd0);
         check("bp sum", {16'h0, s0}, 32'h0100);
      end
      iv[0] = 1'b0;
      drain(0, "bp");
      check("bp sum after drain", {16'h0, s0}, 32'h0100);
      run_op(0, 4, 32'h0F0F, 32'h0101, 1'b0, 1'b0, 32'h1010, 3'b000, "after bp");
      drain(0, "after bp");

      // Reset in the middle of RUN discards the operation.
      a_in[0] = 32'hAAAA; b_in[0] = 32'h0001; opv[0] = 1'b0; cinv[0] = 1'b0; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid reset out_valid", 32'(ov0), 32'd0);
      check("mid reset in_ready", 32'(rdy0), 32'd1);
      check("mid reset sum", {16'h0, s0}, 32'h0);
      check("mid reset flags", 32'({co0, vf0, zf0}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         seen_valid = seen_valid | ov0;
      end
      check("aborted op no out_valid", 32'(seen_valid), 32'd0);
      run_op(0, 4, 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 3'b000, "post reset add");
      drain(0, "post reset add");

      // Other configurations: directed corners, then the reference-model sweep.
      run_op(1, 1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 3'b010, "w8 ovf");
      drain(1, "w8 ovf");
      run_op(1, 1, 32'hFF, 32'h00, 1'b0, 1'b1, 32'h00, 3'b101, "w8 carry-in wrap");
      drain(1, "w8 carry-in wrap");
      run_op(2, 4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 3'b101, "w32 ripple");
      drain(2, "w32 ripple");
      run_op(2, 4, 32'h0, 32'h1, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'b000, "w32 sub");
      drain(2, "w32 sub");
      rand_sweep(1, 8, 1);
      rand_sweep(2, 32, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
